// File: rtl/if_stage_ctrl.sv
// IF stage control: PC, IF/ID and ID/EX registers, stall/flush FSM.
// Optional stall/flush statistics under macro IF_STALL_STATS_EN.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   PCWrite           1 = hold PC (stall)
//   WriteIFID         1 = hold IF/ID register
//   controlMux        1 = bubble (zero control) into ID/EX
//   branch_taken      redirect + flush request
//   branch_target     redirect address
//   instr_in          instruction fetched at pc
//   ctrl_in           control bundle for the instruction in ID
//   pc                current fetch address
//   ifid_instr        IF/ID instruction
//   ifid_pc4          IF/ID PC+4
//   ifid_valid        IF/ID holds a real instruction
//   idex_ctrl         ID/EX control bundle
//   state             00 RUN, 01 STALL, 10 FLUSH
//   stall_err         sticky: stall lasted STALL_LIMIT cycles
//   stall_cycles      total stall cycles (0 without the macro)
//   flush_count       total flushes (0 without the macro)
module if_stage_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          CTRL_W      = 10,
  parameter int          STALL_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PCWrite,
  input  logic              WriteIFID,
  input  logic              controlMux,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic [31:0]       instr_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic [31:0]       pc,
  output logic [31:0]       ifid_instr,
  output logic [31:0]       ifid_pc4,
  output logic              ifid_valid,
  output logic [CTRL_W-1:0] idex_ctrl,
  output logic [1:0]        state,
  output logic              stall_err,
  output logic [31:0]       stall_cycles,
  output logic [15:0]       flush_count
);

  typedef enum logic [1:0] {
    S_RUN   = 2'b00,
    S_STALL = 2'b01,
    S_FLUSH = 2'b10
  } state_t;

  localparam logic [7:0] LIMIT8 = 8'(STALL_LIMIT);

  logic [31:0]       r_pc;
  logic [31:0]       r_ifid_instr;
  logic [31:0]       r_ifid_pc4;
  logic              r_ifid_valid;
  logic [CTRL_W-1:0] r_idex_ctrl;
  state_t            r_state;
  logic [7:0]        r_stall_run;
  logic              r_stall_err;

  logic [31:0] w_pc4;
  logic        w_stall;
  logic        w_bubble;
  logic [7:0]  w_run_inc;

  // Wraps modulo 2^32 by construction.
  assign w_pc4 = r_pc + 32'd4;

  // A flush overrides a stall request in the same cycle.
  assign w_stall = PCWrite & ~branch_taken;

  assign w_bubble = controlMux | branch_taken | ~r_ifid_valid;

  assign w_run_inc = (r_stall_run == 8'hFF) ? 8'hFF
                   : r_stall_run + 8'd1;

  // Program counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (branch_taken) begin
      r_pc <= branch_target;
    end else if (!PCWrite) begin
      r_pc <= w_pc4;
    end
  end

  // IF/ID register; reloads even when PC is held
  // if WriteIFID is low (hazard unit inconsistency).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifid_instr <= 32'd0;
      r_ifid_pc4   <= 32'd0;
      r_ifid_valid <= 1'b0;
    end else if (branch_taken) begin
      r_ifid_instr <= 32'd0;
      r_ifid_pc4   <= 32'd0;
      r_ifid_valid <= 1'b0;
    end else if (!WriteIFID) begin
      r_ifid_instr <= instr_in;
      r_ifid_pc4   <= w_pc4;
      r_ifid_valid <= 1'b1;
    end
  end

  // ID/EX control bundle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idex_ctrl <= '0;
    end else if (w_bubble) begin
      r_idex_ctrl <= '0;
    end else begin
      r_idex_ctrl <= ctrl_in;
    end
  end

  // Pipeline state FSM with stall-run watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_stall_run <= 8'd0;
      r_stall_err <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (branch_taken) begin
            r_state <= S_FLUSH;
          end else if (PCWrite) begin
            r_state <= S_STALL;
          end
        end
        S_STALL: begin
          if (branch_taken) begin
            r_state <= S_FLUSH;
          end else if (!PCWrite) begin
            r_state <= S_RUN;
          end
        end
        S_FLUSH: begin
          if (branch_taken) begin
            r_state <= S_FLUSH;
          end else if (PCWrite) begin
            r_state <= S_STALL;
          end else begin
            r_state <= S_RUN;
          end
        end
        default: begin
          r_state <= S_RUN;
        end
      endcase
      // Run length counts cycles spent in STALL,
      // i.e. edges whose next state is STALL.
      if (w_stall) begin
        r_stall_run <= w_run_inc;
        if (w_run_inc >= LIMIT8) begin
          r_stall_err <= 1'b1;
        end
      end else begin
        r_stall_run <= 8'd0;
      end
    end
  end

`ifdef IF_STALL_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= 32'd0;
      r_flush_count  <= 16'd0;
    end else begin
      if (w_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (branch_taken && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 16'd0;
`endif

  assign pc         = r_pc;
  assign ifid_instr = r_ifid_instr;
  assign ifid_pc4   = r_ifid_pc4;
  assign ifid_valid = r_ifid_valid;
  assign idex_ctrl  = r_idex_ctrl;
  assign state      = r_state;
  assign stall_err  = r_stall_err;

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Bench for if_stage_ctrl: cycle model + compare
// process, plus hand-computed literal checks.
module tb_if_stage_ctrl;

  localparam int CW  = 10;
  localparam int LIM = 3;
`ifdef IF_STALL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          PCWrite = 1'b0;
  logic          WriteIFID = 1'b0;
  logic          controlMux = 1'b0;
  logic          branch_taken = 1'b0;
  logic [31:0]   branch_target = 32'd0;
  logic [31:0]   instr_in;
  logic [CW-1:0] ctrl_in = 10'h2A5;

  logic [31:0]   pc, ifid_instr, ifid_pc4;
  logic          ifid_valid, stall_err;
  logic [CW-1:0] idex_ctrl;
  logic [1:0]    state;
  logic [31:0]   stall_cycles;
  logic [15:0]   flush_count;

  // Instruction memory: word content derived from address.
  assign instr_in = pc ^ 32'h1357_0000;

  if_stage_ctrl #(
    .RESET_PC(32'h0000_0000),
    .CTRL_W(CW),
    .STALL_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .PCWrite(PCWrite), .WriteIFID(WriteIFID),
    .controlMux(controlMux),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .instr_in(instr_in), .ctrl_in(ctrl_in),
    .pc(pc), .ifid_instr(ifid_instr),
    .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
    .idex_ctrl(idex_ctrl), .state(state),
    .stall_err(stall_err),
    .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: what each register must hold after an edge.
  logic [31:0]   m_pc, m_instr, m_pc4;
  logic          m_valid, m_err;
  logic [CW-1:0] m_ctrl;
  int            m_state, m_run, m_sc, m_fc;

  always @(posedge clk) begin : model
    int nst;
    int run;
    if (rst) begin
      m_pc    <= 32'd0;
      m_instr <= 32'd0;
      m_pc4   <= 32'd0;
      m_valid <= 1'b0;
      m_ctrl  <= '0;
      m_state <= 0;
      m_run   <= 0;
      m_err   <= 1'b0;
      m_sc    <= 0;
      m_fc    <= 0;
    end else begin
      nst = branch_taken ? 2 : (PCWrite ? 1 : 0);
      run = (nst == 1) ? ((m_run < 255) ? m_run + 1 : 255) : 0;
      if (branch_taken)  m_pc <= branch_target;
      else if (!PCWrite) m_pc <= m_pc + 32'd4;
      if (branch_taken) begin
        m_instr <= 32'd0;
        m_pc4   <= 32'd0;
        m_valid <= 1'b0;
      end else if (!WriteIFID) begin
        m_instr <= instr_in;
        m_pc4   <= m_pc + 32'd4;
        m_valid <= 1'b1;
      end
      if (controlMux || branch_taken || !m_valid)
        m_ctrl <= '0;
      else
        m_ctrl <= ctrl_in;
      m_state <= nst;
      m_run   <= run;
      if (run >= LIM) m_err <= 1'b1;
      if (nst == 1) m_sc <= m_sc + 1;
      if (branch_taken) m_fc <= m_fc + 1;
    end
  end

  // Compare process, every cycle once the model is seeded.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("ifid_instr", ifid_instr, m_instr);
      chk("ifid_pc4", ifid_pc4, m_pc4);
      chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
      chk("idex_ctrl", 32'(idex_ctrl), 32'(m_ctrl));
      chk("state", 32'(state), 32'(m_state));
      chk("stall_err", 32'(stall_err), 32'(m_err));
      chk("stall_cycles", stall_cycles,
          STATS ? 32'(m_sc) : 32'd0);
      chk("flush_count", 32'(flush_count),
          STATS ? 32'(m_fc) : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic pw, input logic wi,
                        input logic cm, input logic bt,
                        input logic [31:0] tgt);
    PCWrite       = pw;
    WriteIFID     = wi;
    controlMux    = cm;
    branch_taken  = bt;
    branch_target = tgt;
  endtask

  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    chk("L_rst_pc", pc, 32'd0);
    chk("L_rst_valid", 32'(ifid_valid), 32'd0);
    chk("L_rst_state", 32'(state), 32'd0);

    // Free run from reset
    rst = 1'b0;
    tick();
    chk("L_run1_pc", pc, 32'd4);
    chk("L_run1_pc4", ifid_pc4, 32'd4);
    chk("L_run1_instr", ifid_instr, 32'h1357_0000);
    chk("L_run1_valid", 32'(ifid_valid), 32'd1);
    tick();
    chk("L_run2_pc", pc, 32'd8);
    chk("L_run2_ctrl", 32'(idex_ctrl), 32'h2A5);

    // Full stall at pc=8 for two cycles
    set_in(1, 1, 1, 0, 0);
    tick();
    tick();
    chk("L_stall_pc", pc, 32'd8);
    chk("L_stall_instr", ifid_instr, 32'h1357_0004);
    chk("L_stall_ctrl", 32'(idex_ctrl), 32'd0);
    chk("L_stall_state", 32'(state), 32'd1);
    chk("L_stall_sc", stall_cycles, STATS ? 32'd2 : 32'd0);
    chk("L_stall_err0", 32'(stall_err), 32'd0);

    // Branch wins over stall inputs
    set_in(1, 1, 1, 1, 32'h100);
    tick();
    chk("L_br_pc", pc, 32'h100);
    chk("L_br_valid", 32'(ifid_valid), 32'd0);
    chk("L_br_ctrl", 32'(idex_ctrl), 32'd0);
    chk("L_br_state", 32'(state), 32'd2);
    chk("L_br_fc", 32'(flush_count), STATS ? 32'd1 : 32'd0);
    set_in(0, 0, 0, 0, 0);
    tick();
    chk("L_postbr_state", 32'(state), 32'd0);
    chk("L_postbr_pc", pc, 32'h104);

    for (int i = 0; i < 3; i++) begin
      ctrl_in = CW'(10'h31 * (i + 3));
      tick();
    end
    chk("L_free_pc", pc, 32'h110);

    // Long stall with inconsistent WriteIFID=0
    set_in(1, 0, 0, 0, 0);
    tick();
    tick();
    chk("L_lim2_err", 32'(stall_err), 32'd0);
    tick();
    chk("L_lim3_err", 32'(stall_err), 32'd1);
    chk("L_lim3_pc", pc, 32'h110);
    chk("L_lim3_pc4", ifid_pc4, 32'h114);
    tick();
    tick();
    set_in(0, 0, 0, 0, 0);
    tick();
    chk("L_rel_state", 32'(state), 32'd0);
    chk("L_rel_err", 32'(stall_err), 32'd1);
    tick();

    // PC wrap
    set_in(0, 0, 0, 1, 32'hFFFF_FFF8);
    tick();
    set_in(0, 0, 0, 0, 0);
    tick();
    chk("L_top_pc", pc, 32'hFFFF_FFFC);
    tick();
    chk("L_wrap_pc", pc, 32'h0);
    chk("L_wrap_pc4", ifid_pc4, 32'h0);

    // Reset mid-stall
    set_in(1, 1, 1, 0, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("L_mrst_pc", pc, 32'd0);
    chk("L_mrst_instr", ifid_instr, 32'd0);
    chk("L_mrst_valid", 32'(ifid_valid), 32'd0);
    chk("L_mrst_state", 32'(state), 32'd0);
    chk("L_mrst_err", 32'(stall_err), 32'd0);
    chk("L_mrst_sc", stall_cycles, 32'd0);

    // Reset overrides branch
    set_in(0, 0, 0, 1, 32'h200);
    tick();
    chk("L_rbr_pc", pc, 32'd0);
    chk("L_rbr_fc", 32'(flush_count), 32'd0);
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0);
    tick();
    chk("L_rbr2_pc", pc, 32'd4);
    tick();

    // Flush followed by stall
    set_in(1, 1, 0, 1, 32'h40);
    tick();
    chk("L_fs_state1", 32'(state), 32'd2);
    set_in(1, 1, 0, 0, 0);
    tick();
    chk("L_fs_state2", 32'(state), 32'd1);
    chk("L_fs_pc", pc, 32'h40);
    set_in(0, 0, 0, 0, 0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
